// File: rtl/gray_decoder.sv
// gray_decoder
// Receiving end of a W-bit Gray counter link. Each valid sample is converted
// to binary and checked against the previous accepted value. A hold or a
// single-step advance keeps the block locked, and a step from all-ones to zero
// is counted as a wrap. Any other change is a fault, which lasts until Clr.
//
// Ports:
//   Clk        system clock; all state updates on the rising edge
//   Reset      synchronous, active-low reset (0 = reset)
//   Valid      a Gray sample is present this cycle
//   Gray       Gray-coded count (W bits)
//   Clr        leaves FAULT for UNLOCKED; ignored in other states
//   Bin        registered binary value of the last accepted (or offending) sample
//   Locked     1 while in LOCKED
//   Error      1 while in FAULT
//   Overflow   one-cycle pulse after an accepted all-ones -> zero wrap
//   WrapCount  wraps since lock, saturating at 2^CW-1
//   state_dbg  current FSM state: 0 = UNLOCKED, 1 = LOCKED, 2 = FAULT
//
// Handshake: a sample is taken on any rising edge with Valid=1. There is no
// back-pressure. In FAULT, samples are dropped until Clr returns the block
// to UNLOCKED.
module gray_decoder #(
    parameter int W  = 3,
    parameter int CW = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Valid,
    input  logic [W-1:0]  Gray,
    input  logic          Clr,
    output logic [W-1:0]  Bin,
    output logic          Locked,
    output logic          Error,
    output logic          Overflow,
    output logic [CW-1:0] WrapCount,
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_FAULT    = 2'd2
    } state_t;

    localparam logic [W-1:0]  ALL_ONES = '1;
    localparam logic [CW-1:0] WC_MAX   = '1;

    state_t       state;
    logic [W-1:0] prev;
    logic [W-1:0] conv;

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [W-1:0] gray_to_bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign conv      = gray_to_bin(Gray);
    assign state_dbg = state;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state     <= ST_UNLOCKED;
            prev      <= '0;
            Bin       <= '0;
            Locked    <= 1'b0;
            Error     <= 1'b0;
            Overflow  <= 1'b0;
            WrapCount <= '0;
        end else begin
            Overflow <= 1'b0;
            case (state)
                ST_UNLOCKED: begin
                    // The first sample always locks. No wrap is counted,
                    // even if the sample is zero.
                    if (Valid) begin
                        Bin       <= conv;
                        prev      <= conv;
                        WrapCount <= '0;
                        Locked    <= 1'b1;
                        Error     <= 1'b0;
                        state     <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (Valid) begin
                        if (conv == prev) begin
                            // Upstream counter stalled: nothing changes.
                        end else if (prev == ALL_ONES && conv == '0) begin
                            Bin      <= '0;
                            prev     <= '0;
                            Overflow <= 1'b1;
                            if (WrapCount != WC_MAX) begin
                                WrapCount <= WrapCount + CW'(1);
                            end
                        end else if (conv == prev + W'(1)) begin
                            Bin  <= conv;
                            prev <= conv;
                        end else begin
                            // Show the offending value on Bin so it can be inspected.
                            Bin    <= conv;
                            Locked <= 1'b0;
                            Error  <= 1'b1;
                            state  <= ST_FAULT;
                        end
                    end
                end
                ST_FAULT: begin
                    // Clr wins over Valid. A sample that arrives with Clr is dropped.
                    if (Clr) begin
                        Error <= 1'b0;
                        state <= ST_UNLOCKED;
                    end
                end
                default: begin
                    Locked <= 1'b0;
                    Error  <= 1'b0;
                    state  <= ST_UNLOCKED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gray_decoder.sv
// Bench for gray_decoder. It drives two instances from the same inputs: one
// with the default 8-bit wrap counter, and one with a 2-bit wrap counter so
// that saturation is reached quickly. A reference model computes the expected
// outputs from the decoding rules, using integer arithmetic on binary positions.
module tb_gray_decoder;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Valid = 1'b0;
    logic [2:0] Gray = 3'b000;
    logic       Clr = 1'b0;

    logic [2:0] bin_m,  bin_s;
    logic       locked_m, locked_s, error_m, error_s, ovf_m, ovf_s;
    logic [7:0] wc_m;
    logic [1:0] wc_s;
    logic [1:0] st_m, st_s;

    int vectors = 0;
    int miscompares = 0;

    always #5 Clk = ~Clk;

    gray_decoder #(.W(3), .CW(8)) dut_main (
        .Clk(Clk), .Reset(Reset), .Valid(Valid), .Gray(Gray), .Clr(Clr),
        .Bin(bin_m), .Locked(locked_m), .Error(error_m), .Overflow(ovf_m),
        .WrapCount(wc_m), .state_dbg(st_m)
    );

    gray_decoder #(.W(3), .CW(2)) dut_sat (
        .Clk(Clk), .Reset(Reset), .Valid(Valid), .Gray(Gray), .Clr(Clr),
        .Bin(bin_s), .Locked(locked_s), .Error(error_s), .Overflow(ovf_s),
        .WrapCount(wc_s), .state_dbg(st_s)
    );

    logic [13:0] act_main;
    logic [7:0]  act_sat;
    assign act_main = {bin_m, locked_m, error_m, ovf_m, wc_m};
    assign act_sat  = {bin_s, locked_s, error_s, ovf_s, wc_s};

    // ---------------- reference model ----------------
    // m_st: 0 = unlocked, 1 = locked, 2 = fault
    int         m_st = 0;
    logic [2:0] m_bin = 3'd0;
    logic [2:0] m_prev = 3'd0;
    int         m_wraps = 0;
    logic       m_ovf = 1'b0;

    // Find the binary position whose Gray code matches g.
    function automatic logic [2:0] g2b(input logic [2:0] g);
        logic [2:0] bb;
        for (int b = 0; b < 8; b++) begin
            bb = 3'(b);
            if ((bb ^ (bb >> 1)) == g) return bb;
        end
        return 3'd0;
    endfunction

    function automatic logic [2:0] b2g(input int b);
        logic [2:0] bb;
        bb = 3'(b % 8);
        return bb ^ (bb >> 1);
    endfunction

    task automatic model_step(input logic r, input logic v, input logic [2:0] g, input logic c);
        logic [2:0] n;
        if (!r) begin
            m_st = 0; m_bin = 3'd0; m_prev = 3'd0; m_wraps = 0; m_ovf = 1'b0;
        end else begin
            n = g2b(g);
            m_ovf = 1'b0;
            if (m_st == 0) begin
                if (v) begin
                    m_st = 1; m_bin = n; m_prev = n; m_wraps = 0;
                end
            end else if (m_st == 1) begin
                if (v && n != m_prev) begin
                    if (int'(n) == (int'(m_prev) + 1) % 8) begin
                        m_bin = n; m_prev = n;
                        if (n == 3'd0) begin
                            m_ovf = 1'b1;
                            m_wraps++;
                        end
                    end else begin
                        m_st = 2; m_bin = n;
                    end
                end
            end else begin
                if (c) m_st = 0;
            end
        end
    endtask

    function automatic logic [13:0] exp_main();
        logic [7:0] wc;
        wc = (m_wraps > 255) ? 8'd255 : 8'(m_wraps);
        return {m_bin, m_st == 1, m_st == 2, m_ovf, wc};
    endfunction

    function automatic logic [7:0] exp_sat();
        logic [1:0] wc;
        wc = (m_wraps > 3) ? 2'd3 : 2'(m_wraps);
        return {m_bin, m_st == 1, m_st == 2, m_ovf, wc};
    endfunction

    // Drive one cycle's inputs at the falling edge and advance the model at
    // the rising edge. Outputs can then be sampled 1 time unit later.
    task automatic cycle(input logic r, input logic v, input logic [2:0] g, input logic c);
        @(negedge Clk);
        Reset = r; Valid = v; Gray = g; Clr = c;
        @(posedge Clk);
        model_step(r, v, g, c);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        cycle(1'b0, 1'b1, 3'b101, 1'b1);
        cycle(1'b0, 1'b0, 3'b000, 1'b0);
        vectors++;
        if (act_main !== 14'd0) begin
            miscompares++;
            $display("FAIL reset_main: got %h expected %h", act_main, 14'd0);
        end
        vectors++;
        if (act_sat !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_sat: got %h expected %h", act_sat, 8'd0);
        end
    endtask

    task automatic test_normal();
        logic [2:0] seq [8];
        seq = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b1, seq[i], 1'b0);
            vectors++;
            if ({bin_m, locked_m, error_m, ovf_m} !== {3'(i), 1'b1, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL normal_step%0d: got bin=%0d lk=%b er=%b ov=%b expected bin=%0d lk=1 er=0 ov=0",
                         i, bin_m, locked_m, error_m, ovf_m, i);
            end
        end
    endtask

    task automatic test_wrap();
        int b;
        int ovf_count;
        cycle(1'b1, 1'b1, 3'b000, 1'b0);
        vectors++;
        if ({bin_m, ovf_m, wc_m} !== {3'd0, 1'b1, 8'd1}) begin
            miscompares++;
            $display("FAIL wrap_first: got bin=%0d ov=%b wc=%0d expected bin=0 ov=1 wc=1", bin_m, ovf_m, wc_m);
        end
        cycle(1'b1, 1'b1, 3'b001, 1'b0);
        vectors++;
        if ({bin_m, ovf_m, wc_m} !== {3'd1, 1'b0, 8'd1}) begin
            miscompares++;
            $display("FAIL wrap_after: got bin=%0d ov=%b wc=%0d expected bin=1 ov=0 wc=1", bin_m, ovf_m, wc_m);
        end
        b = 1;
        ovf_count = 0;
        for (int k = 0; k < 24; k++) begin
            b = (b + 1) % 8;
            cycle(1'b1, 1'b1, b2g(b), 1'b0);
            if (ovf_m === 1'b1) ovf_count++;
            vectors++;
            if (act_main !== exp_main()) begin
                miscompares++;
                $display("FAIL wrap_run%0d: got %h expected %h", k, act_main, exp_main());
            end
        end
        vectors++;
        if (wc_m !== 8'd4 || ovf_count != 3) begin
            miscompares++;
            $display("FAIL wrap_total: got wc=%0d pulses=%0d expected wc=4 pulses=3", wc_m, ovf_count);
        end
    endtask

    task automatic test_stall();
        cycle(1'b1, 1'b1, 3'b011, 1'b0);   // advance 1 -> 2
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 1'b1, 3'b011, 1'b0);
            vectors++;
            if ({bin_m, locked_m, error_m, ovf_m} !== {3'd2, 1'b1, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL stall_hold%0d: got bin=%0d lk=%b er=%b ov=%b expected bin=2 lk=1 er=0 ov=0",
                         k, bin_m, locked_m, error_m, ovf_m);
            end
        end
        cycle(1'b1, 1'b1, 3'b010, 1'b0);
        vectors++;
        if ({bin_m, error_m, ovf_m} !== {3'd3, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL stall_release: got bin=%0d er=%b ov=%b expected bin=3 er=0 ov=0", bin_m, error_m, ovf_m);
        end
    endtask

    task automatic test_illegal();
        cycle(1'b0, 1'b0, 3'b000, 1'b0);
        cycle(1'b1, 1'b1, 3'b001, 1'b0);
        cycle(1'b1, 1'b1, 3'b110, 1'b0);
        vectors++;
        if ({bin_m, locked_m, error_m, wc_m} !== {3'd4, 1'b0, 1'b1, 8'd0}) begin
            miscompares++;
            $display("FAIL illegal_fault: got bin=%0d lk=%b er=%b wc=%0d expected bin=4 lk=0 er=1 wc=0",
                     bin_m, locked_m, error_m, wc_m);
        end
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b1, 3'($urandom_range(0, 7)), 1'b0);
            vectors++;
            if ({bin_m, error_m} !== {3'd4, 1'b1}) begin
                miscompares++;
                $display("FAIL illegal_ignore%0d: got bin=%0d er=%b expected bin=4 er=1", k, bin_m, error_m);
            end
        end
        cycle(1'b1, 1'b1, 3'b000, 1'b1);
        vectors++;
        if ({bin_m, locked_m, error_m} !== {3'd4, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL illegal_clr: got bin=%0d lk=%b er=%b expected bin=4 lk=0 er=0", bin_m, locked_m, error_m);
        end
        cycle(1'b1, 1'b1, 3'b111, 1'b0);
        vectors++;
        if ({bin_m, locked_m, error_m} !== {3'd5, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL illegal_relock: got bin=%0d lk=%b er=%b expected bin=5 lk=1 er=0", bin_m, locked_m, error_m);
        end
    endtask

    task automatic test_reset_mid();
        cycle(1'b0, 1'b0, 3'b000, 1'b0);
        cycle(1'b1, 1'b1, 3'b000, 1'b0);
        for (int b = 1; b <= 22; b++) cycle(1'b1, 1'b1, b2g(b), 1'b0);
        vectors++;
        if ({bin_m, locked_m, wc_m} !== {3'd6, 1'b1, 8'd2}) begin
            miscompares++;
            $display("FAIL midreset_pre: got bin=%0d lk=%b wc=%0d expected bin=6 lk=1 wc=2", bin_m, locked_m, wc_m);
        end
        cycle(1'b0, 1'b1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        vectors++;
        if (act_main !== 14'd0) begin
            miscompares++;
            $display("FAIL midreset_zero: got %h expected %h", act_main, 14'd0);
        end
        cycle(1'b1, 1'b1, 3'b010, 1'b0);
        vectors++;
        if ({bin_m, locked_m, error_m, ovf_m, wc_m} !== {3'd3, 1'b1, 1'b0, 1'b0, 8'd0}) begin
            miscompares++;
            $display("FAIL midreset_relock: got %h expected bin=3 lk=1 er=0 ov=0 wc=0", act_main);
        end
    endtask

    task automatic test_saturation();
        int pulses;
        cycle(1'b0, 1'b0, 3'b000, 1'b0);
        cycle(1'b1, 1'b1, 3'b000, 1'b0);
        pulses = 0;
        for (int b = 1; b <= 40; b++) begin
            cycle(1'b1, 1'b1, b2g(b), 1'b0);
            if (ovf_s === 1'b1) pulses++;
            vectors++;
            if (act_sat !== exp_sat()) begin
                miscompares++;
                $display("FAIL sat_step%0d: got %h expected %h", b, act_sat, exp_sat());
            end
        end
        vectors++;
        if (wc_s !== 2'd3 || wc_m !== 8'd5 || pulses != 5) begin
            miscompares++;
            $display("FAIL sat_total: got wc_s=%0d wc_m=%0d pulses=%0d expected wc_s=3 wc_m=5 pulses=5",
                     wc_s, wc_m, pulses);
        end
    endtask

    task automatic test_random();
        int sel;
        logic r, v, c;
        logic [2:0] g;
        for (int k = 0; k < 600; k++) begin
            r = ($urandom_range(0, 99) >= 2);
            v = ($urandom_range(0, 99) < 80);
            sel = $urandom_range(0, 99);
            if (sel < 55)      g = b2g(int'(m_prev) + 1);
            else if (sel < 75) g = b2g(int'(m_prev));
            else               g = 3'($urandom_range(0, 7));
            c = ($urandom_range(0, 99) < ((m_st == 2) ? 30 : 10));
            cycle(r, v, g, c);
            vectors++;
            if (act_main !== exp_main()) begin
                miscompares++;
                $display("FAIL random_main%0d: got %h expected %h", k, act_main, exp_main());
            end
            vectors++;
            if (act_sat !== exp_sat()) begin
                miscompares++;
                $display("FAIL random_sat%0d: got %h expected %h", k, act_sat, exp_sat());
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_wrap();
        test_stall();
        test_illegal();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/gray_decoder.md
Name: gray_decoder

Overview:
- Receiving end of the 3-bit Gray counter interface.
- Samples a Gray-coded count and converts it to binary.
- Tracks lock to a legal Gray sequence: accepts holds and single-step advances, counts wrap-arounds, and flags illegal transitions.
- Sits downstream of the gray counter; used by the sequence-check bench and by any consumer needing binary position.

Parameters:
- W, 3, width of the Gray input and binary output.
- CW, 8, width of the wrap counter.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-low reset; sampled on the rising edge of Clk; 0 = reset.
- Valid  input  1  Gray sample present this cycle.
- Gray  input  W  Gray-coded count.
- Clr  input  1  clears the FAULT state and returns the block to UNLOCKED; ignored in other states.
- Bin  output  W  registered binary value of the last accepted sample.
- Locked  output  1  1 while in state LOCKED.
- Error  output  1  1 while in state FAULT.
- Overflow  output  1  one-cycle pulse on an accepted wrap from all-ones to zero.
- WrapCount  output  CW  number of wraps since lock.

Behaviour:
- Conversion: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i] for i=W-2..0. Purely combinational; the result is registered, so Bin has 1-cycle latency from the Valid sample.
- Reset (Reset=0 at an edge) forces, regardless of other inputs:
  - state=UNLOCKED, Bin=0, Locked=0, Error=0, Overflow=0, WrapCount=0.
  - Internal previous-binary register = 0.
- Reset asserted mid-sequence discards lock and count. The first valid sample after release relocks.
- Overflow defaults to 0 every cycle unless set by a wrap in LOCKED.
- State UNLOCKED:
  - Valid=1: Bin<=conv(Gray), prev<=conv(Gray), go to LOCKED, WrapCount<=0. No wrap is counted even if Gray=0.
  - Valid=0: stay; outputs hold.
- State LOCKED (let n=conv(Gray), p=prev):
  - Valid=0: hold everything.
  - n==p (counter stalled, En low upstream): legal; no change to Bin or WrapCount.
  - n==p+1 (mod 2^W) and p!=2^W-1: legal advance; Bin<=n, prev<=n.
  - p==2^W-1 and n==0: legal wrap. Bin<=0, prev<=0, Overflow=1 for exactly the next cycle, WrapCount<=WrapCount+1.
  - WrapCount saturates at 2^CW-1; when saturated, Overflow still pulses.
  - Any other n (skip, backward step, multi-bit change): illegal. Go to FAULT. Bin<=n so the offending value is visible. WrapCount holds.
- State FAULT:
  - Error=1, Locked=0. Valid samples are ignored; Bin and WrapCount hold.
  - Clr=1: next state UNLOCKED, Error<=0.
  - Clr=1 and Valid=1 in the same cycle: go to UNLOCKED only; the sample is not consumed.
- Precedence: Reset > Clr(FAULT) > Valid.
- Locked, Error, Overflow and WrapCount are all registered and change on the same edge as the state.

Test Plan:
1. Normal count: Reset=0 for 2 cycles, then 1; Valid=1 with Gray sequence 000,001,011,010,110,111,101,100 (W=3) -> Bin=0,1,2,3,4,5,6,7, each one cycle after its sample; Locked=1 from the first sample; Error=0 throughout.
2. Wrap: continue from 100 to 000, then 001 -> Bin=0, then 1; Overflow=1 exactly one cycle (with Bin=0); WrapCount 0->1. Repeat 3 full cycles -> WrapCount=4.
3. Stall: in LOCKED at Gray=011, hold Gray=011 for 5 cycles with Valid=1, then 010 -> Bin stays 2, then 3; no Error, no Overflow.
4. Illegal step: locked at 001 (Bin=1), present 110 -> next cycle Error=1, Locked=0, Bin=4, WrapCount unchanged. Further samples ignored. Clr=1 with Valid=1 -> UNLOCKED, Error=0. Next Valid with Gray=111 -> Locked=1, Bin=5.
5. Reset mid-operation: locked, WrapCount=2, Bin=6; Reset=0 for one edge -> all outputs 0, Locked=0. After release, first sample 010 -> Locked=1, Bin=3, WrapCount=0, no Overflow.
6. Saturation (CW=2 override): run 5 wraps -> WrapCount stops at 3; Overflow pulses on all 5 wraps.
